// File: rtl/local_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : local_bus_pkg
// Description : Shared strobe levels, DSACK port-size encodings and the bus
//               sequencer state type for the 68030 local bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package local_bus_pkg;

    // CPU/VME strobes are active-low
    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    // DSACK[1:0] port-size encodings seen by the 68030
    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    // Bus-cycle sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        ACK  = 3'd2,
        VME  = 3'd3,
        BERR = 3'd4
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/local_bus_controller_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer with parameterized width and reset
//               value, used to bring asynchronous VME strobes into clk.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture; the first stage may go metastable, the second settles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/local_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : local_bus_controller
// Description : 68030 local bus-cycle sequencer. Terminates ROM/RAM/serial
//               cycles with per-device wait states and DSACK port size,
//               forwards synchronized VME DSACK/BERR to the CPU.
//               Optional macro LOCAL_BUS_TIMEOUT_EN adds a bus-error timeout
//               for VME cycles that are never answered.
// Revision    : 1.0 - initial release
// ============================================================================
module local_bus_controller
    import local_bus_pkg::*;
#(
    parameter int ROM_WAIT       = 3,
    parameter int RAM_WAIT       = 1,
    parameter int SERIAL_WAIT    = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_as,
    input  logic       request_rom,
    input  logic       request_ram,
    input  logic       request_serial,
    input  logic       request_vme_a16,
    input  logic       request_vme_a24,
    input  logic       request_vme_a40,
    input  logic [1:0] vme_dsack,
    input  logic       vme_berr,
    output logic [1:0] cpu_dsack,
    output logic       cpu_berr
);

    localparam logic [3:0] c_rom_wait    = 4'(ROM_WAIT);
    localparam logic [3:0] c_ram_wait    = 4'(RAM_WAIT);
    localparam logic [3:0] c_serial_wait = 4'(SERIAL_WAIT);

    // Reject wait/timeout values the 4-bit and 8-bit counters cannot hold
    if (ROM_WAIT < 0 || ROM_WAIT > 15 || RAM_WAIT < 0 || RAM_WAIT > 15 ||
        SERIAL_WAIT < 0 || SERIAL_WAIT > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("local_bus_controller: parameter out of range");
    end

    bus_state_t r_state;
    bus_state_t w_state_next;
    logic [3:0] r_wait;
    logic [3:0] w_wait_next;
    logic [1:0] r_size;
    logic [1:0] w_size_next;
    logic [1:0] r_dsack;
    logic [1:0] w_dsack_next;
    logic       r_berr;
    logic       w_berr_next;

    logic [1:0] w_vme_dsack_sync;
    logic       w_vme_berr_sync;
    logic       w_vme_req;
    logic       w_as_active;
    logic       w_timeout_hit;

    sync2 #(
        .WIDTH       (2),
        .RESET_VALUE (2'b11)
    ) u_sync_dsack (
        .clk     (clk),
        .rst     (reset),
        .i_async (vme_dsack),
        .o_sync  (w_vme_dsack_sync)
    );

    sync2 #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_sync_berr (
        .clk     (clk),
        .rst     (reset),
        .i_async (vme_berr),
        .o_sync  (w_vme_berr_sync)
    );

    assign w_as_active = (cpu_as == ACTIVE);
    assign w_vme_req   = (request_vme_a16 == ACTIVE) ||
                         (request_vme_a24 == ACTIVE) ||
                         (request_vme_a40 == ACTIVE);

`ifdef LOCAL_BUS_TIMEOUT_EN
    localparam logic [7:0] c_timeout_cycles = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_timeout;
    logic [7:0] w_timeout_inc;

    // Saturating increment so a stuck cycle never wraps back below the limit
    assign w_timeout_inc = (r_timeout == 8'hFF) ? r_timeout : r_timeout + 8'd1;
    assign w_timeout_hit = (w_vme_dsack_sync == DSACK_NONE) &&
                           (w_timeout_inc >= c_timeout_cycles);

    // Count VME cycles with no DSACK seen; cleared whenever the bus is idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout <= 8'd0;
        end else if (r_state == IDLE) begin
            r_timeout <= 8'd0;
        end else if (r_state == VME && w_vme_dsack_sync == DSACK_NONE) begin
            r_timeout <= w_timeout_inc;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    // State, wait counter, latched port size and registered CPU strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_wait  <= 4'd0;
            r_size  <= DSACK_NONE;
            r_dsack <= DSACK_NONE;
            r_berr  <= INACTIVE;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            r_size  <= w_size_next;
            r_dsack <= w_dsack_next;
            r_berr  <= w_berr_next;
        end
    end

    // Next-state and next-output decode; outputs describe the state being entered
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_size_next  = r_size;
        w_dsack_next = DSACK_NONE;
        w_berr_next  = INACTIVE;

        unique case (r_state)
            IDLE: begin
                if (w_as_active && request_rom == ACTIVE) begin
                    w_state_next = WAIT;
                    w_wait_next  = c_rom_wait;
                    w_size_next  = DSACK_16;
                end else if (w_as_active && request_ram == ACTIVE) begin
                    w_state_next = WAIT;
                    w_wait_next  = c_ram_wait;
                    w_size_next  = DSACK_32;
                end else if (w_as_active && request_serial == ACTIVE) begin
                    w_state_next = WAIT;
                    w_wait_next  = c_serial_wait;
                    w_size_next  = DSACK_8;
                end else if (w_vme_req) begin
                    w_state_next = VME;
                end
            end

            WAIT: begin
                // An abort on the final wait cycle still suppresses DSACK
                if (!w_as_active) begin
                    w_state_next = IDLE;
                end else if (r_wait == 4'd0) begin
                    w_state_next = ACK;
                    w_dsack_next = r_size;
                end else begin
                    w_wait_next = r_wait - 4'd1;
                end
            end

            ACK: begin
                if (!w_as_active) begin
                    w_state_next = IDLE;
                end else begin
                    w_dsack_next = r_size;
                end
            end

            VME: begin
                // Bus error outranks any DSACK synchronized in the same cycle
                if (!w_as_active) begin
                    w_state_next = IDLE;
                end else if (w_vme_berr_sync == ACTIVE || w_timeout_hit) begin
                    w_state_next = BERR;
                    w_berr_next  = ACTIVE;
                end else begin
                    w_dsack_next = w_vme_dsack_sync;
                end
            end

            BERR: begin
                if (!w_as_active) begin
                    w_state_next = IDLE;
                end else begin
                    w_berr_next = ACTIVE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign cpu_dsack = r_dsack;
    assign cpu_berr  = r_berr;

endmodule
`default_nettype wire

// File: tb/tb_local_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_local_bus_controller
// Description : Self-checking bench for local_bus_controller: a cycle-level
//               behavioural model compared every clock, plus directed
//               literal expectations for each bus-cycle scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_local_bus_controller;

    localparam int TB_TIMEOUT = 8;
    localparam int M_IDLE  = 0;
    localparam int M_LOCAL = 1;
    localparam int M_VME   = 2;
    localparam int M_BERR  = 3;

    logic       clk             = 1'b0;
    logic       reset           = 1'b1;
    logic       cpu_as          = 1'b1;
    logic       request_rom     = 1'b1;
    logic       request_ram     = 1'b1;
    logic       request_serial  = 1'b1;
    logic       request_vme_a16 = 1'b1;
    logic       request_vme_a24 = 1'b1;
    logic       request_vme_a40 = 1'b1;
    logic [1:0] vme_dsack       = 2'b11;
    logic       vme_berr        = 1'b1;
    logic [1:0] cpu_dsack;
    logic       cpu_berr;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int         m_mode    = M_IDLE;
    int         m_elapsed = 0;
    int         m_wait    = 0;
    logic [1:0] m_size    = 2'b11;
    int         m_vcount  = 0;
    logic [1:0] m_dh1 = 2'b11, m_dh2 = 2'b11;
    logic       m_bh1 = 1'b1,  m_bh2 = 1'b1;
    logic [1:0] exp_dsack = 2'b11;
    logic       exp_berr  = 1'b1;

    always #5 clk = ~clk;

    local_bus_controller #(
        .ROM_WAIT       (3),
        .RAM_WAIT       (1),
        .SERIAL_WAIT    (6),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_as          (cpu_as),
        .request_rom     (request_rom),
        .request_ram     (request_ram),
        .request_serial  (request_serial),
        .request_vme_a16 (request_vme_a16),
        .request_vme_a24 (request_vme_a24),
        .request_vme_a40 (request_vme_a40),
        .vme_dsack       (vme_dsack),
        .vme_berr        (vme_berr),
        .cpu_dsack       (cpu_dsack),
        .cpu_berr        (cpu_berr)
    );

    // Behavioural model: local cycles acknowledge W+1 edges after the start
    // edge; VME strobes are seen by the sequencer two edges after sampling.
    initial begin : model
        logic [1:0] sd;
        logic       sb;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_mode = M_IDLE; m_elapsed = 0; m_vcount = 0;
                m_dh1 = 2'b11; m_dh2 = 2'b11; m_bh1 = 1'b1; m_bh2 = 1'b1;
                exp_dsack = 2'b11; exp_berr = 1'b1;
            end else begin
                sd = m_dh2; sb = m_bh2;
                m_dh2 = m_dh1; m_bh2 = m_bh1;
                m_dh1 = vme_dsack; m_bh1 = vme_berr;
                exp_dsack = 2'b11; exp_berr = 1'b1;
                case (m_mode)
                    M_IDLE: begin
                        m_elapsed = 0;
                        if (cpu_as == 1'b0 && request_rom == 1'b0) begin
                            m_mode = M_LOCAL; m_wait = 3; m_size = 2'b01;
                        end else if (cpu_as == 1'b0 && request_ram == 1'b0) begin
                            m_mode = M_LOCAL; m_wait = 1; m_size = 2'b00;
                        end else if (cpu_as == 1'b0 && request_serial == 1'b0) begin
                            m_mode = M_LOCAL; m_wait = 6; m_size = 2'b10;
                        end else if (!(request_vme_a16 && request_vme_a24 && request_vme_a40)) begin
                            m_mode = M_VME; m_vcount = 0;
                        end
                    end
                    M_LOCAL: begin
                        m_elapsed = m_elapsed + 1;
                        if (cpu_as) m_mode = M_IDLE;
                        else if (m_elapsed >= m_wait + 1) exp_dsack = m_size;
                    end
                    M_VME: begin
                        if (cpu_as) begin
                            m_mode = M_IDLE;
                        end else if (sb == 1'b0) begin
                            m_mode = M_BERR; exp_berr = 1'b0;
                        end else begin
`ifdef LOCAL_BUS_TIMEOUT_EN
                            if (sd == 2'b11 && m_vcount < 255) m_vcount = m_vcount + 1;
                            if (sd == 2'b11 && m_vcount >= TB_TIMEOUT) begin
                                m_mode = M_BERR; exp_berr = 1'b0;
                            end else begin
                                exp_dsack = sd;
                            end
`else
                            exp_dsack = sd;
`endif
                        end
                    end
                    default: begin
                        if (cpu_as) m_mode = M_IDLE;
                        else exp_berr = 1'b0;
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin : cmp_proc
        forever begin
            @(posedge clk);
            #2;
            n_tests++;
            if (cpu_dsack !== exp_dsack || cpu_berr !== exp_berr) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: cpu_dsack=%b cpu_berr=%b, required %b/%b",
                         $time, cpu_dsack, cpu_berr, exp_dsack, exp_berr);
            end
        end
    end

    task automatic expect_out(input string name, input logic [1:0] d, input logic b);
        n_tests++;
        if (cpu_dsack !== d || cpu_berr !== b) begin
            n_fail++;
            $display("FAIL %s: cpu_dsack=%b cpu_berr=%b, required %b/%b",
                     name, cpu_dsack, cpu_berr, d, b);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic bus_release();
        cpu_as = 1'b1;
        request_rom = 1'b1; request_ram = 1'b1; request_serial = 1'b1;
        request_vme_a16 = 1'b1; request_vme_a24 = 1'b1; request_vme_a40 = 1'b1;
        vme_dsack = 2'b11; vme_berr = 1'b1;
    endtask

    initial begin : stim
        step(3);
        reset = 1'b0;
        expect_out("reset_state", 2'b11, 1'b1);
        step(2);

        // RAM, 1 wait: DSACK 32-bit after E2, released after E5
        cpu_as = 1'b0; request_ram = 1'b0;
        step();  expect_out("ram_e0", 2'b11, 1'b1);
        step();  expect_out("ram_e1", 2'b11, 1'b1);
        step();  expect_out("ram_e2", 2'b00, 1'b1);
        step(2); expect_out("ram_hold_e4", 2'b00, 1'b1);
        bus_release();
        step();  expect_out("ram_negate_e5", 2'b11, 1'b1);
        step(2);

        // Serial, 6 waits: DSACK 8-bit after E7
        cpu_as = 1'b0; request_serial = 1'b0;
        step(); step(6); expect_out("serial_e6", 2'b11, 1'b1);
        step();          expect_out("serial_e7", 2'b10, 1'b1);
        bus_release(); step(3);

        // ROM, 3 waits: DSACK 16-bit after E4
        cpu_as = 1'b0; request_rom = 1'b0;
        step(); step(3); expect_out("rom_e3", 2'b11, 1'b1);
        step();          expect_out("rom_e4", 2'b01, 1'b1);
        bus_release(); step(3);

        // All requests at once: ROM wins
        cpu_as = 1'b0; request_rom = 1'b0; request_ram = 1'b0;
        request_serial = 1'b0; request_vme_a16 = 1'b0;
        step(); step(4); expect_out("priority_rom", 2'b01, 1'b1);
        bus_release(); step(3);

        // Abort on the cycle the wait counter reaches zero
        cpu_as = 1'b0; request_ram = 1'b0;
        step(); step();
        cpu_as = 1'b1;
        step(); expect_out("abort_at_zero", 2'b11, 1'b1);
        bus_release(); step(3);

        // Abort part-way through serial wait states
        cpu_as = 1'b0; request_serial = 1'b0;
        step(3);
        bus_release();
        step(8); expect_out("abort_mid", 2'b11, 1'b1);

        // Normal RAM cycle after aborts
        cpu_as = 1'b0; request_ram = 1'b0;
        step(); step(2); expect_out("ram_after_abort", 2'b00, 1'b1);
        bus_release(); step(2);

        // Back-to-back: AS re-asserted right after negation, request held
        cpu_as = 1'b0; request_ram = 1'b0;
        step(); step(2);
        cpu_as = 1'b1;
        step(); expect_out("b2b_gap", 2'b11, 1'b1);
        cpu_as = 1'b0;
        step(); expect_out("b2b_e0", 2'b11, 1'b1);
        step(2); expect_out("b2b_e2", 2'b00, 1'b1);
        bus_release(); step(3);

        // VME A24: DSACK applied before edge 5, forwarded after edge 7
        cpu_as = 1'b0; request_vme_a24 = 1'b0;
        step(); step(4);
        vme_dsack = 2'b00;
        step(); step(); expect_out("vme_e6", 2'b11, 1'b1);
        step();         expect_out("vme_fwd_e7", 2'b00, 1'b1);
        step(2);        expect_out("vme_hold", 2'b00, 1'b1);
        bus_release();
        step();         expect_out("vme_release", 2'b11, 1'b1);
        step(3);

        // VME A16: BERR and DSACK synchronized together, BERR wins
        cpu_as = 1'b0; request_vme_a16 = 1'b0;
        step();
        vme_dsack = 2'b00; vme_berr = 1'b0;
        step(2); expect_out("berr_e2", 2'b11, 1'b1);
        step();  expect_out("berr_wins", 2'b11, 1'b0);
        step(2); expect_out("berr_hold", 2'b11, 1'b0);
        bus_release();
        step();  expect_out("berr_release", 2'b11, 1'b1);
        step(3);

        // Unanswered VME A40 cycle
        cpu_as = 1'b0; request_vme_a40 = 1'b0;
        step();
`ifdef LOCAL_BUS_TIMEOUT_EN
        step(7); expect_out("timeout_e7", 2'b11, 1'b1);
        step();  expect_out("timeout_e8", 2'b11, 1'b0);
        step(3); expect_out("timeout_hold", 2'b11, 1'b0);
`else
        step(300); expect_out("no_timeout", 2'b11, 1'b1);
`endif
        bus_release();
        step();  expect_out("timeout_release", 2'b11, 1'b1);
        step(2);

        // Reset asserted mid-cycle during ACK clears outputs immediately
        cpu_as = 1'b0; request_ram = 1'b0;
        step(); step(2); expect_out("pre_reset_ack", 2'b00, 1'b1);
        #1 reset = 1'b1;
        #1 expect_out("reset_async", 2'b11, 1'b1);
        bus_release();
        step(2);
        reset = 1'b0;
        step();
        cpu_as = 1'b0; request_ram = 1'b0;
        step(); step(2); expect_out("post_reset_ram", 2'b00, 1'b1);
        bus_release(); step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
